match_ctrl: RTL and testbench
=============================

Name: match_ctrl

Overview:
- Game-flow controller for the pong datapath.
- Sequences attract, serve delay, serve, rally and game-over phases.
- Gates ball motion, issues ball re-centre/serve pulses, keeps both player scores and declares the winner.
- Sits between the joystick decoder outputs, the ball/miss logic and the score/attract display, in the pixel-rate (ce) domain.

Parameters:
- WIN_SCORE, 11: score that ends the match; legal range 1..15.
- SERVE_FRAMES, 60: frames spent in WAIT before each serve; legal range 1..1023.
- OVER_FRAMES, 300: frames spent in OVER before returning to IDLE; legal range 1..1023.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  pixel-rate clock enable; all non-reset state advances only when ce=1.
- vsync  in  1  vertical sync from the video timing; its rising edge is the frame tick.
- joy1  in  8  player 1 controls, active-high; bit 4 = fire.
- joy2  in  8  player 2 controls, active-high; bit 4 = fire.
- missL  in  1  ball left the field on the left edge; point to player 2.
- missR  in  1  ball left the field on the right edge; point to player 1.
- run  out  1  ball motion enable.
- serve  out  1  one-ce-cycle pulse: ball to centre and launch.
- serveDir  out  1  launch direction: 0 = toward the left player, 1 = toward the right player.
- score1  out  4  player 1 score, binary.
- score2  out  4  player 2 score, binary.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- state  out  3  current state code, for the display overlay.

Behaviour:
- Reset:
  - State = IDLE.
  - run=0, serve=0, serveDir=0, score1=score2=0, winner=00.
  - Frame counter = 0; fire-edge register and vsync-edge register = 0.
  - Reset wins over ce.
- Edge detectors, updated on ce:
  - fireEdge = (joy1[4]|joy2[4]) & ~firePrev.
  - frameTick = vsync & ~vsyncPrev.
- State codes: IDLE=0, WAIT=1, SERVE=2, PLAY=3, OVER=4. Codes 5..7 return to IDLE on the next ce.
- IDLE:
  - run=0.
  - On fireEdge: clear scores, winner=00, serveDir=0, frame counter=0, go to WAIT.
- WAIT:
  - run=0.
  - Frame counter increments on each frameTick.
  - When the counter reaches SERVE_FRAMES: clear the counter, go to SERVE.
- SERVE:
  - serve=1 for exactly this one ce cycle; run=0.
  - Next ce: go to PLAY.
- PLAY:
  - run=1.
  - On missL:
    - score2 += 1, serveDir=0, run drops at the same update.
    - If the new score2 == WIN_SCORE: winner=10, go to OVER. Otherwise go to WAIT.
  - On missR: symmetric; score1 += 1, serveDir=1, winner=01.
  - missL and missR in the same ce cycle: missL takes priority, missR is discarded.
  - fireEdge is ignored.
- Miss inputs outside PLAY are ignored.
- OVER:
  - run=0; scores and winner are held.
  - Frame counter counts frameTick up to OVER_FRAMES, then clears and goes to IDLE.
  - fireEdge is ignored.
- In IDLE, scores and winner remain visible until the next start.
- Latency:
  - Outputs are registered.
  - A miss sampled at ce cycle N is reflected in score, run and state after the clock edge of cycle N.
  - The serve pulse appears one ce after WAIT expires.
- Width and range rules:
  - Frame counter is 10 bits; no wrap within legal parameter ranges.
  - Scores cannot exceed WIN_SCORE.
- Held fire across a restart does not retrigger; a release and re-press is required.
- ce=0 freezes all state; edges are only detected on ce cycles.
- Reset asserted mid-rally returns to IDLE within one clock, with serve=0 and run=0.

Test Plan:
- Reset, then one fire press on joy1[4] -> state 0→1; scores 0; after 60 vsync rising edges, serve is high for exactly one ce, then state=3 and run=1.
- In PLAY, pulse missR -> score1=1, serveDir=1, run=0, state=1; 60 frames later serve pulses again.
- Pulse missL 11 times across rallies -> on the 11th, score2=11, winner=10, state=4; after 300 frames state=0 with scores still held; the next fire press clears scores and winner.
- missL and missR asserted in the same ce cycle in PLAY -> only score2 increments.
- Fire held continuously through OVER→IDLE -> no start occurs; release and press -> state=1.
- Reset asserted while in PLAY with score1=5 -> next clock: state=0, run=0, serve=0, score1=0; missL pulses in IDLE/WAIT change nothing.

Source files
------------

// File: rtl/match_ctrl.sv
// Pong game-flow controller: attract, serve delay, serve, rally and game-over phases.
// Keeps both scores, gates ball motion and issues the serve pulse; all state advances on ce.
module match_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       vsync,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  input  logic       missL,
  input  logic       missR,
  output logic       run,
  output logic       serve,
  output logic       serveDir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SERVE = 3'd2,
    ST_PLAY  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Counters compare against the last count so the move happens on the N-th tick itself.
  localparam logic [9:0] SERVE_LAST = 10'(SERVE_FRAMES - 1);
  localparam logic [9:0] OVER_LAST  = 10'(OVER_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     r_state;
  logic [9:0] r_cnt;
  logic       r_fire_prev;
  logic       r_vsync_prev;
  logic       r_run;
  logic       r_serve;
  logic       r_dir;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [1:0] r_win;

  state_t     w_state_nxt;
  logic [9:0] w_cnt_nxt;
  logic       w_dir_nxt;
  logic [3:0] w_s1_nxt;
  logic [3:0] w_s2_nxt;
  logic [1:0] w_win_nxt;
  logic       w_fire;
  logic       w_fire_edge;
  logic       w_tick;
  logic       w_unused;

  assign w_fire      = joy1[4] | joy2[4];
  assign w_fire_edge = w_fire & ~r_fire_prev;
  assign w_tick      = vsync & ~r_vsync_prev;
  assign w_unused    = ^{joy1[7:5], joy1[3:0], joy2[7:5], joy2[3:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_win_nxt   = r_win;
    case (r_state)
      ST_IDLE: begin
        if (w_fire_edge) begin
          w_s1_nxt    = 4'd0;
          w_s2_nxt    = 4'd0;
          w_win_nxt   = 2'b00;
          w_dir_nxt   = 1'b0;
          w_cnt_nxt   = 10'd0;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_cnt_nxt   = 10'd0;
            w_state_nxt = ST_SERVE;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end
      end
      ST_SERVE: w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        // missL wins a simultaneous double miss
        if (missL) begin
          w_s2_nxt  = r_s2 + 4'd1;
          w_dir_nxt = 1'b0;
          if (r_s2 + 4'd1 == WIN) begin
            w_win_nxt   = 2'b10;
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else if (missR) begin
          w_s1_nxt  = r_s1 + 4'd1;
          w_dir_nxt = 1'b1;
          if (r_s1 + 4'd1 == WIN) begin
            w_win_nxt   = 2'b01;
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_OVER: begin
        if (w_tick) begin
          if (r_cnt == OVER_LAST) begin
            w_cnt_nxt   = 10'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 10'd0;
      r_fire_prev  <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_run        <= 1'b0;
      r_serve      <= 1'b0;
      r_dir        <= 1'b0;
      r_s1         <= 4'd0;
      r_s2         <= 4'd0;
      r_win        <= 2'b00;
    end else if (ce) begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fire_prev  <= w_fire;
      r_vsync_prev <= vsync;
      r_run        <= (w_state_nxt == ST_PLAY);
      r_serve      <= (w_state_nxt == ST_SERVE);
      r_dir        <= w_dir_nxt;
      r_s1         <= w_s1_nxt;
      r_s2         <= w_s2_nxt;
      r_win        <= w_win_nxt;
    end
  end

  assign run      = r_run;
  assign serve    = r_serve;
  assign serveDir = r_dir;
  assign score1   = r_s1;
  assign score2   = r_s2;
  assign winner   = r_win;
  assign state    = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: stimulus queues each expected output change,
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_match_ctrl;

  localparam int SF = 60;
  localparam int OF = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       vsync = 1'b0;
  logic [7:0] joy1 = 8'h00;
  logic [7:0] joy2 = 8'h00;
  logic       missL = 1'b0;
  logic       missR = 1'b0;
  logic       run, serve, serveDir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  match_ctrl #(.WIN_SCORE(11), .SERVE_FRAMES(SF), .OVER_FRAMES(OF)) dut (
    .clock(clock), .reset(reset), .ce(ce), .vsync(vsync),
    .joy1(joy1), .joy2(joy2), .missL(missL), .missR(missR),
    .run(run), .serve(serve), .serveDir(serveDir),
    .score1(score1), .score2(score2), .winner(winner), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] vec;
    int          frm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tb_frames = 0;
  int   n_trans = 0;
  int   sdur = 0;
  bit   mon_en = 1'b0;

  logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0;
  logic [1:0] m_win = 2'b00;
  logic       m_dir = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] cur_vec();
    return {state, run, serve, serveDir, score1, score2, winner};
  endfunction

  function automatic void push(input logic [2:0] st, input logic r, input logic s, input int frm);
    exp_t e;
    e.vec = {st, r, s, m_dir, m_s1, m_s2, m_win};
    e.frm = frm;
    q.push_back(e);
  endfunction

  // Monitor: every change of the observed outputs must match the next queued expectation.
  logic [15:0] prev_vec = 16'h0;
  always @(negedge clock) begin
    logic [15:0] cv;
    exp_t        e;
    cv = cur_vec();
    if (mon_en && cv != prev_vec) begin
      if (q.size() == 0) begin
        chk($sformatf("unexpected_change%0d", n_trans), longint'(cv), longint'(prev_vec));
      end else begin
        e = q.pop_front();
        chk($sformatf("trans%0d_outputs", n_trans), longint'(cv), longint'(e.vec));
        chk($sformatf("trans%0d_frame", n_trans), tb_frames, e.frm);
      end
      n_trans++;
    end
    prev_vec = cv;
    if (mon_en) begin
      if (serve) sdur++;
      else if (sdur != 0) begin
        chk("serve_width", sdur, 1);
        sdur = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frame();
    tb_frames++;
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(2);
  endtask

  task automatic start_press();
    m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00; m_dir = 1'b0;
    push(3'd1, 1'b0, 1'b0, tb_frames);
    joy1[4] = 1'b1;
    cyc(1);
    joy1[4] = 1'b0;
    cyc(1);
  endtask

  task automatic serve_cycle();
    push(3'd2, 1'b0, 1'b1, tb_frames + SF);
    push(3'd3, 1'b1, 1'b0, tb_frames + SF);
    repeat (SF) frame();
    cyc(2);
  endtask

  task automatic miss(input bit left, input bit both);
    if (left) begin
      m_s2++;
      m_dir = 1'b0;
      if (m_s2 == 4'd11) m_win = 2'b10;
    end else begin
      m_s1++;
      m_dir = 1'b1;
      if (m_s1 == 4'd11) m_win = 2'b01;
    end
    push((m_win != 2'b00) ? 3'd4 : 3'd1, 1'b0, 1'b0, tb_frames);
    missL = left | both;
    missR = ~left | both;
    cyc(1);
    missL = 1'b0;
    missR = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(2);
    chk("reset_outputs", longint'(cur_vec()), 0);
    mon_en = 1'b1;

    // first start and serve
    start_press();
    serve_cycle();

    // ce=0 freezes everything: miss and a whole vsync pulse are ignored
    ce = 1'b0;
    missR = 1'b1;
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    missR = 1'b0;
    cyc(2);
    ce = 1'b1;
    cyc(2);

    miss(1'b0, 1'b0);
    serve_cycle();

    // simultaneous miss: left wins
    miss(1'b1, 1'b1);
    serve_cycle();

    // run player 2 up to the winning score
    while (m_win == 2'b00) begin
      miss(1'b1, 1'b0);
      if (m_win == 2'b00) serve_cycle();
    end

    // fire held through OVER into IDLE must not restart
    joy2[4] = 1'b1;
    push(3'd0, 1'b0, 1'b0, tb_frames + OF);
    repeat (OF) frame();
    cyc(10);
    joy2[4] = 1'b0;
    cyc(2);
    start_press();
    serve_cycle();

    repeat (5) begin
      miss(1'b0, 1'b0);
      serve_cycle();
    end
    chk("score1_before_reset", score1, 5);

    // reset mid-rally, with ce low: reset still wins
    m_s1 = 4'd0; m_s2 = 4'd0; m_win = 2'b00; m_dir = 1'b0;
    push(3'd0, 1'b0, 1'b0, tb_frames);
    ce = 1'b0;
    reset = 1'b1;
    cyc(1);
    chk("reset_state", state, 0);
    chk("reset_run", run, 0);
    chk("reset_serve", serve, 0);
    chk("reset_score1", score1, 0);
    reset = 1'b0;
    ce = 1'b1;
    cyc(2);

    // misses in IDLE and WAIT change nothing
    missL = 1'b1; cyc(1); missL = 1'b0; cyc(2);
    start_press();
    missL = 1'b1; cyc(1); missL = 1'b0; cyc(2);
    missR = 1'b1; cyc(1); missR = 1'b0; cyc(2);
    repeat (5) frame();
    cyc(20);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
